// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall controller. Combines ID load-use hazards,
// multi-cycle EX occupancy (MUL/DIV) and MEM bus wait states into the
// 6-bit stall vector; the deepest stalled stage wins.
module pipe_ctrl #(
  parameter int REG_AW      = 3,
  parameter int MUL_CYCLES  = 3,
  parameter int DIV_CYCLES  = 17,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_raddr1,
  input  logic [REG_AW-1:0] id_raddr2,
  input  logic              ex_is_load,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_mc_req,
  input  logic              ex_mc_div,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic [5:0]        stall,
  output logic              ex_mc_done,
  output logic              mem_err
);

  localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(MEM_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_RUN,
    EX_HOLD
  } ex_state_e;

  typedef enum logic {
    M_IDLE,
    M_WAIT
  } mem_state_e;

  ex_state_e        ex_state_q, ex_state_d;
  mem_state_e       mem_state_q, mem_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic lu_stall;
  logic mem_stall;
  logic mem_err_c;
  logic ex_hold;
  logic ex_done_c;

  // Load-use hazard: stateless, a bubble in EX clears it next cycle.
  always_comb begin
    lu_stall = ex_is_load & ex_wreg &
               ((id_re1 & (id_raddr1 == ex_wd)) | (id_re2 & (id_raddr2 == ex_wd)));
  end

  // MEM wait-state FSM with forced release after MEM_TIMEOUT stalled cycles.
  always_comb begin
    mem_state_d = mem_state_q;
    timer_d     = timer_q;
    mem_stall   = 1'b0;
    mem_err_c   = 1'b0;
    unique case (mem_state_q)
      M_IDLE: begin
        if (mem_req && !mem_ack) begin
          mem_stall   = 1'b1;
          timer_d     = TMR_ONE;
          mem_state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        if (mem_ack || !mem_req) begin
          mem_state_d = M_IDLE;
        end else if (timer_q == TMR_MAX) begin
          mem_err_c   = 1'b1;
          mem_state_d = M_IDLE;
        end else begin
          mem_stall = 1'b1;
          timer_d   = timer_q + TMR_ONE;
        end
      end
      default: mem_state_d = M_IDLE;
    endcase
  end

  // EX multi-cycle FSM; HOLD leaves only when the internally computed
  // stall[3] (which reduces to mem_stall in this state) is clear.
  always_comb begin
    ex_state_d = ex_state_q;
    cnt_d      = cnt_q;
    ex_hold    = 1'b0;
    ex_done_c  = 1'b0;
    unique case (ex_state_q)
      EX_IDLE: begin
        if (ex_mc_req) begin
          ex_hold    = 1'b1;
          cnt_d      = ex_mc_div ? DIV_LOAD : MUL_LOAD;
          ex_state_d = EX_RUN;
        end
      end
      EX_RUN: begin
        ex_hold = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          ex_state_d = EX_HOLD;
        end
      end
      EX_HOLD: begin
        ex_done_c = 1'b1;
        if (!mem_stall) begin
          ex_state_d = EX_IDLE;
        end
      end
      default: ex_state_d = EX_IDLE;
    endcase
  end

  // Stall vector priority and reset gating of all outputs.
  always_comb begin
    stall      = '0;
    ex_mc_done = 1'b0;
    mem_err    = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall = 6'b011111;
      end else if (ex_hold) begin
        stall = 6'b001111;
      end else if (lu_stall) begin
        stall = 6'b000111;
      end
      ex_mc_done = ex_done_c;
      mem_err    = mem_err_c;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_state_q  <= EX_IDLE;
      mem_state_q <= M_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
    end else begin
      ex_state_q  <= ex_state_d;
      mem_state_q <= mem_state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline stall controller for the 16-bit 5-stage CPU. It produces the 6-bit `stall` vector consumed by the PC and by every pipeline register, including the bubble insertion in ID/EX and EX/MEM. It combines three stall sources: ID load-use hazards, multi-cycle EX operations (MUL/DIV occupancy counter), and MEM-stage bus wait states (with a timeout). Each source is tracked by its own small FSM, and the deepest stalled stage wins.

## Interface
Parameters:
- `REG_AW`, default 3: register address width.
- `MUL_CYCLES`, default 3: number of cycles `stall[3]` is held for a MUL; minimum 2.
- `DIV_CYCLES`, default 17: number of cycles `stall[3]` is held for a DIV; minimum 2.
- `MEM_TIMEOUT`, default 255: maximum MEM wait cycles before a forced release; minimum 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `id_re1`, `id_re2`  in  1 each  ID reads source operand 1 / 2.
- `id_raddr1`, `id_raddr2`  in  `REG_AW` each  ID source register addresses.
- `ex_is_load`  in  1  instruction in EX is a load.
- `ex_wreg`  in  1  instruction in EX writes a register.
- `ex_wd`  in  `REG_AW`  EX destination register address.
- `ex_mc_req`  in  1  instruction in EX is multi-cycle; level, held while the instruction sits in EX.
- `ex_mc_div`  in  1  multi-cycle op type: 1 = DIV, 0 = MUL. Sampled on the start cycle.
- `mem_req`  in  1  MEM stage has an active bus access.
- `mem_ack`  in  1  bus completes the access this cycle.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = Stop.
- `ex_mc_done`  out  1  multi-cycle result valid; EX selects the result this cycle.
- `mem_err`  out  1  one-cycle pulse on MEM timeout.

## Operation
Stall vector, combinational from state and inputs. Priority, highest first:
- `mem_stall` → `6'b011111`
- else `ex_hold` → `6'b001111`
- else `lu_stall` → `6'b000111`
- else `6'b000000`

`stall[5]` is never asserted.

Load-use hazard:
- `lu_stall` = `ex_is_load & ex_wreg & ((id_re1 & id_raddr1==ex_wd) | (id_re2 & id_raddr2==ex_wd))`.
- No state is kept. ID/EX turns the stalled cycle into a bubble, so the next cycle re-evaluates with the bubble in EX.

EX FSM, states `EX_IDLE`, `EX_RUN`, `EX_HOLD`. `cnt` is wide enough for `DIV_CYCLES`.
- `EX_IDLE`: if `ex_mc_req` is high, assert `ex_hold`, load `cnt` = (`ex_mc_div` ? `DIV_CYCLES` : `MUL_CYCLES`) − 2, and go to `EX_RUN`.
- `EX_RUN`: assert `ex_hold`. If `cnt` != 0, decrement `cnt`; if `cnt` == 0, go to `EX_HOLD`.
- `EX_HOLD`: `ex_mc_done` = 1 and `ex_hold` = 0.
  - If `stall[3]` == 0 (the instruction advances at this edge), go to `EX_IDLE`.
  - Otherwise (a MEM stall is active) stay in `EX_HOLD` with `ex_mc_done` held high. The op is never restarted.
- Result: `stall[3]` is asserted by the EX source for exactly N cycles (N = `MUL_CYCLES` or `DIV_CYCLES`). The instruction occupies EX for N+1 cycles when no MEM stall occurs.
- The EX counter keeps running while a MEM stall overrides the vector.

MEM FSM, states `M_IDLE`, `M_WAIT`. `timer` is wide enough for `MEM_TIMEOUT`.
- `M_IDLE`:
  - `mem_req & ~mem_ack`: `mem_stall` = 1, `timer` ← 1, go to `M_WAIT`.
  - `mem_req & mem_ack`: zero-wait access, no stall.
- `M_WAIT`:
  - `mem_ack` = 1: `mem_stall` = 0, go to `M_IDLE`.
  - `mem_req` = 0: abort; `mem_stall` = 0, go to `M_IDLE`.
  - `timer` == `MEM_TIMEOUT`, no ack: `mem_err` = 1, `mem_stall` = 0 (forced release), go to `M_IDLE`.
  - Otherwise: `mem_stall` = 1 and `timer` increments.
- With no ack, `stall[4]` is asserted for exactly `MEM_TIMEOUT` cycles, then one release cycle carries `mem_err`.

## Timing
- Reset:
  - While `rst` is high: `stall` = 0, `ex_mc_done` = 0, `mem_err` = 0.
  - At the reset edge: FSMs go to `EX_IDLE` / `M_IDLE`; `cnt` and `timer` go to 0.
  - A reset mid-operation aborts both FSMs; a pending MUL/DIV is not resumed.
- All outputs are combinational, valid in the same cycle as their inputs; state updates on `posedge clk`.
- Outputs never depend combinationally on `stall` feeding back from downstream logic. The `stall[3]` check in `EX_HOLD` uses the internally computed `mem_stall`.
- When MEM and EX events occur in the same cycle, both FSMs advance independently and only the vector priority resolves the outcome.
- `ex_mc_req` rising while in `EX_HOLD` or `EX_RUN` is ignored (same instruction).

## Test plan
- Load-use: `ex_is_load`=1, `ex_wreg`=1, `ex_wd`=3, `id_re2`=1, `id_raddr2`=3 → `stall`=`000111` for 1 cycle. Same setup with `id_raddr2`=4 → `stall`=0.
- MUL: `ex_mc_req`=1, `ex_mc_div`=0, `MUL_CYCLES`=3 → `stall`=`001111` for 3 cycles, then `ex_mc_done`=1 with `stall`=0 for 1 cycle, then `EX_IDLE`. DIV with `DIV_CYCLES`=17 → 17 stall cycles.
- MEM wait: `mem_req`=1, `mem_ack` arrives on the 4th cycle → `stall`=`011111` for 3 cycles, 0 on the ack cycle. `mem_req`=1 with `mem_ack`=1 in the first cycle → no stall.
- Timeout: `MEM_TIMEOUT`=8, no ack → 8 cycles of `011111`, then `mem_err`=1 for 1 cycle with `stall`=0.
- Overlap: DIV in `EX_HOLD` while a MEM wait of 5 cycles is active → `stall`=`011111`, `ex_mc_done` stays 1 for all 5 cycles, no restart. On the ack cycle `stall`=0 and EX returns to `EX_IDLE`.
- Reset mid-DIV (cycle 6 of 17) → next cycle `stall`=0. A following `ex_mc_req` restarts with the full 17 cycles.
